// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared receiver encodings, frame limits and controller state type
//
// Purpose: constants and types shared by the frame buffer controller files.
// Ports: none (package).

package rx_pkg;

  // Receiver state encodings (istate)
  localparam logic [2:0] RX_IDLE = 3'b000;
  localparam logic [2:0] RX_DA   = 3'b011;
  localparam logic [2:0] RX_SA   = 3'b100;
  localparam logic [2:0] RX_LEN  = 3'b101;
  localparam logic [2:0] RX_DATA = 3'b110;
  localparam logic [2:0] RX_FCS  = 3'b111;

  // CRC-32 register value after running over a frame including a correct FCS
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  localparam logic [10:0] MIN_FRAME = 11'd64;
  localparam logic [10:0] MAX_FRAME = 11'd1522;

  // Controller FSM state
  typedef logic [2:0] ctrl_state_t;
  localparam ctrl_state_t ST_IDLE   = 3'd0;
  localparam ctrl_state_t ST_WRITE  = 3'd1;
  localparam ctrl_state_t ST_CHECK  = 3'd2;
  localparam ctrl_state_t ST_COMMIT = 3'd3;
  localparam ctrl_state_t ST_DROP   = 3'd4;

  // DA through FCS are the states whose bytes land in packet memory
  function automatic logic is_frame_state(input logic [2:0] st);
    return (st >= RX_DA);
  endfunction

endpackage

// File: rtl/rx_frame_buffer_ctrl_if.sv
// rtl/rx_frame_buffer_ctrl_if.sv - reader-side channel: descriptor handshake and space release
//
// Purpose: bundles the signals exchanged with the downstream copy/read engine.
// Signals:
//   o_desc_valid / o_desc_addr / o_desc_len : descriptor from controller
//   i_desc_ready                            : reader accepts descriptor
//   i_rel / i_rel_len                       : reader returns consumed bytes
// Modports: master = controller side, slave = reader side.

interface rx_frame_buffer_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic              o_desc_valid;
  logic [ADDR_W-1:0] o_desc_addr;
  logic [10:0]       o_desc_len;
  logic              i_desc_ready;
  logic              i_rel;
  logic [10:0]       i_rel_len;

  modport master (
    output o_desc_valid, o_desc_addr, o_desc_len,
    input  i_desc_ready, i_rel, i_rel_len
  );

  modport slave (
    input  o_desc_valid, o_desc_addr, o_desc_len,
    output i_desc_ready, i_rel, i_rel_len
  );
endinterface

// File: rtl/rx_desc_fifo.sv
// rtl/rx_desc_fifo.sv - synchronous descriptor FIFO with full/empty flags
//
// Purpose: holds committed frame descriptors until the reader takes them.
// Ports:
//   iclk, irst_n : clock, asynchronous active-low reset
//   i_push, i_wdata : write request and data
//   i_pop        : read request (ignored when empty)
//   o_rdata      : head entry (show-ahead)
//   o_full, o_empty : status flags

module rx_desc_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is fine when a pop frees the slot in the same cycle
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge iclk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/rx_frame_buffer_ctrl.sv
// rtl/rx_frame_buffer_ctrl.sv - speculative frame writer with commit/rollback into circular packet memory
//
// Purpose: writes received frame bytes into a circular byte memory, then commits
// good frames as descriptors or rolls the write pointer back on bad ones.
// Ports:
//   iclk, irst_n                 : clock, asynchronous active-low reset
//   istate/ichange/idata/idv/ierror/ircrc : frame receiver outputs
//   o_mem_we/o_mem_waddr/o_mem_wdata      : registered memory write port
//   desc_if (master)             : descriptor handshake and space release
//   o_frame_cnt, o_drop_cnt      : wrapping committed / dropped frame counters
//   o_busy                       : FSM not in IDLE

module rx_frame_buffer_ctrl
  import rx_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int DESC_DEPTH = 8
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic [2:0]        istate,
  input  logic              ichange,
  input  logic [7:0]        idata,
  input  logic              idv,
  input  logic              ierror,
  input  logic [31:0]       ircrc,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_waddr,
  output logic [7:0]        o_mem_wdata,
  rx_frame_buffer_ctrl_if.master desc_if,
  output logic [15:0]       o_frame_cnt,
  output logic [15:0]       o_drop_cnt,
  output logic              o_busy
);
  localparam int SUM_W = ((ADDR_W > 11) ? ADDR_W : 11) + 3;
  localparam logic [ADDR_W:0] MEM_BYTES = {1'b1, {ADDR_W{1'b0}}};

  ctrl_state_t       r_state;
  ctrl_state_t       w_next;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_cptr;
  logic [ADDR_W-1:0] r_start;
  logic [10:0]       r_len;
  logic [ADDR_W:0]   r_free;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_waddr;
  logic [7:0]        r_mem_wdata;
  logic [15:0]       r_frame_cnt;
  logic [15:0]       r_drop_cnt;

  logic              w_byte;
  logic              w_abort;
  logic              w_accept;
  logic              w_check_ok;
  logic              w_enter_drop;
  logic [SUM_W-1:0]  w_free_sum;
  logic [ADDR_W:0]   w_free_next;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [ADDR_W+10:0] w_fifo_rdata;

  assign w_byte = (r_state == ST_WRITE) && idv && is_frame_state(istate);
  // A byte that cannot be stored (no space, or frame too long) kills the frame instead
  assign w_abort = (r_state == ST_WRITE) &&
                   (ierror || (w_byte && ((r_free == '0) || (r_len == MAX_FRAME))));
  assign w_accept = w_byte && !w_abort;
  assign w_check_ok = (ircrc == CRC_RESIDUE) && (r_len >= MIN_FRAME) &&
                      (r_len <= MAX_FRAME) && !w_fifo_full;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (ichange && istate == RX_DA) w_next = ST_WRITE;
      ST_WRITE: begin
        if (w_abort)                          w_next = ST_DROP;
        else if (ichange && istate == RX_IDLE) w_next = ST_CHECK;
      end
      ST_CHECK:  w_next = w_check_ok ? ST_COMMIT : ST_DROP;
      ST_COMMIT: w_next = ST_IDLE;
      ST_DROP:   if (istate == RX_IDLE) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  assign w_enter_drop = (w_next == ST_DROP) && (r_state != ST_DROP);

  // Release, byte write and rollback may coincide; all are applied, then capped
  always_comb begin
    w_free_sum = SUM_W'(r_free)
               + (desc_if.i_rel ? SUM_W'(desc_if.i_rel_len) : '0)
               + (w_enter_drop ? SUM_W'(r_len) : '0)
               - SUM_W'(w_accept);
    if (w_free_sum > SUM_W'(MEM_BYTES)) w_free_next = MEM_BYTES;
    else                                w_free_next = w_free_sum[ADDR_W:0];
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_state     <= ST_IDLE;
      r_wptr      <= '0;
      r_cptr      <= '0;
      r_start     <= '0;
      r_len       <= '0;
      r_free      <= MEM_BYTES;
      r_mem_we    <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state  <= w_next;
      r_free   <= w_free_next;
      r_mem_we <= w_accept;
      if (w_accept) begin
        r_mem_waddr <= r_wptr;
        r_mem_wdata <= idata;
        r_wptr      <= r_wptr + 1'b1;
        r_len       <= r_len + 1'b1;
      end
      if (r_state == ST_IDLE && w_next == ST_WRITE) begin
        r_start <= r_wptr;
        r_len   <= '0;
      end
      if (r_state == ST_COMMIT) begin
        r_cptr      <= r_wptr;
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      if (w_enter_drop) begin
        r_wptr     <= r_cptr;
        r_len      <= '0;
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  rx_desc_fifo #(
    .WIDTH (ADDR_W + 11),
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .iclk    (iclk),
    .irst_n  (irst_n),
    .i_push  (r_state == ST_COMMIT),
    .i_wdata ({r_start, r_len}),
    .i_pop   (desc_if.i_desc_ready),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Head entry gated so descriptor outputs read zero while the FIFO is empty
  assign desc_if.o_desc_valid = !w_fifo_empty;
  assign desc_if.o_desc_addr  = w_fifo_empty ? '0 : w_fifo_rdata[ADDR_W+10:11];
  assign desc_if.o_desc_len   = w_fifo_empty ? '0 : w_fifo_rdata[10:0];

  assign o_mem_we    = r_mem_we;
  assign o_mem_waddr = r_mem_waddr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_frame_cnt = r_frame_cnt;
  assign o_drop_cnt  = r_drop_cnt;
  assign o_busy      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_rx_frame_buffer_ctrl.sv
// tb/tb_rx_frame_buffer_ctrl.sv - scoreboard bench for rx_frame_buffer_ctrl

module tb_rx_frame_buffer_ctrl;
  localparam logic [31:0] RESIDUE = 32'hC704DD7B;

  logic        iclk = 1'b0;
  logic        irst_n;
  logic [2:0]  istate;
  logic        ichange;
  logic [7:0]  idata;
  logic        idv;
  logic        ierror;
  logic [31:0] ircrc;
  logic        o_mem_we;
  logic [10:0] o_mem_waddr;
  logic [7:0]  o_mem_wdata;
  logic [15:0] o_frame_cnt;
  logic [15:0] o_drop_cnt;
  logic        o_busy;

  rx_frame_buffer_ctrl_if #(.ADDR_W(11)) dif ();

  rx_frame_buffer_ctrl #(.ADDR_W(11), .DESC_DEPTH(8)) dut (
    .iclk        (iclk),
    .irst_n      (irst_n),
    .istate      (istate),
    .ichange     (ichange),
    .idata       (idata),
    .idv         (idv),
    .ierror      (ierror),
    .ircrc       (ircrc),
    .o_mem_we    (o_mem_we),
    .o_mem_waddr (o_mem_waddr),
    .o_mem_wdata (o_mem_wdata),
    .desc_if     (dif),
    .o_frame_cnt (o_frame_cnt),
    .o_drop_cnt  (o_drop_cnt),
    .o_busy      (o_busy)
  );

  always #5 iclk = ~iclk;

  int n_vec = 0;
  int n_err = 0;
  logic [18:0] exp_wr[$];
  logic [21:0] exp_desc[$];
  int m_wptr  = 0;
  int m_frame = 0;
  int m_drop  = 0;
  int m_seq   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every memory write and every descriptor beat is checked in order
  always @(negedge iclk) begin
    if (irst_n) begin
      if (o_mem_we) begin
        if (exp_wr.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL mem_unexpected: got addr %0d data %0h expected no write", o_mem_waddr, o_mem_wdata);
        end else begin
          check("mem_write", {o_mem_waddr, o_mem_wdata}, exp_wr.pop_front());
        end
      end
      if (dif.o_desc_valid) begin
        if (exp_desc.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL desc_unexpected: got addr %0d len %0d expected none", dif.o_desc_addr, dif.o_desc_len);
        end else if (dif.i_desc_ready) begin
          check("desc_pop", {dif.o_desc_addr, dif.o_desc_len}, exp_desc.pop_front());
        end else begin
          check("desc_hold", {dif.o_desc_addr, dif.o_desc_len}, exp_desc[0]);
        end
      end
    end
  end

  function automatic logic [2:0] st_for(input int i, input int len);
    if (i < 6)        return 3'b011;
    if (i < 12)       return 3'b100;
    if (i < 14)       return 3'b101;
    if (i >= len - 4) return 3'b111;
    return 3'b110;
  endfunction

  function automatic logic [7:0] byte_for(input int i);
    return 8'(i * 3 + m_seq * 17);
  endfunction

  task automatic start_frame();
    @(negedge iclk);
    istate = 3'b011; ichange = 1'b1; idv = 1'b0; ircrc = 32'h0;
  endtask

  task automatic drive_byte(input int i, input int len, input int err_at);
    logic [2:0] st;
    @(negedge iclk);
    st = st_for(i, len);
    ichange = (st != istate);
    istate = st; idv = 1'b1; idata = byte_for(i); ierror = (i == err_at);
  endtask

  // len bytes sent; n_wr of them are expected in memory; commit is the expected outcome
  task automatic send_frame(input int len, input bit good, input int err_at,
                            input int n_wr, input bit commit);
    for (int i = 0; i < n_wr; i++)
      exp_wr.push_back({11'((m_wptr + i) % 2048), byte_for(i)});
    if (commit) begin
      exp_desc.push_back({11'(m_wptr), 11'(len)});
      m_wptr = (m_wptr + len) % 2048;
      m_frame++;
    end else begin
      m_drop++;
    end
    start_frame();
    for (int i = 0; i < len; i++) drive_byte(i, len, err_at);
    @(negedge iclk);
    idv = 1'b0; ierror = 1'b0; istate = 3'b000; ichange = 1'b1;
    ircrc = good ? RESIDUE : ~RESIDUE;
    @(negedge iclk);
    ichange = 1'b0;
    repeat (5) @(negedge iclk);
    check("frame_cnt", o_frame_cnt, 16'(m_frame));
    check("drop_cnt", o_drop_cnt, 16'(m_drop));
    check("busy_after_frame", o_busy, 1'b0);
    m_seq++;
  endtask

  task automatic release_bytes(input int n);
    @(negedge iclk);
    dif.i_rel = 1'b1; dif.i_rel_len = 11'(n);
    @(negedge iclk);
    dif.i_rel = 1'b0; dif.i_rel_len = 11'd0;
  endtask

  task automatic wait_drained(input string name);
    int cyc;
    cyc = 0;
    while ((exp_wr.size() != 0 || exp_desc.size() != 0) && cyc < 200) begin
      @(negedge iclk);
      cyc++;
    end
    check({name, "_wr_left"}, exp_wr.size(), 0);
    check({name, "_desc_left"}, exp_desc.size(), 0);
  endtask

  initial begin
    irst_n = 1'b0; istate = 3'b000; ichange = 1'b0; idata = 8'h00;
    idv = 1'b0; ierror = 1'b0; ircrc = 32'h0;
    dif.i_desc_ready = 1'b1; dif.i_rel = 1'b0; dif.i_rel_len = 11'd0;
    repeat (3) @(negedge iclk);
    check("reset_outputs", {o_mem_we, o_mem_waddr, o_mem_wdata, dif.o_desc_valid, dif.o_desc_addr,
                            dif.o_desc_len, o_frame_cnt, o_drop_cnt, o_busy}, '0);
    irst_n = 1'b1;
    repeat (2) @(negedge iclk);

    // Good 64-byte frame at 0..63, descriptor {0,64}
    send_frame(64, 1'b1, -1, 64, 1'b1);
    // Bad CRC: written speculatively at 64..163, then rolled back
    send_frame(100, 1'b0, -1, 100, 1'b0);
    // Runt with good CRC
    send_frame(60, 1'b1, -1, 60, 1'b0);
    // ierror on byte 30: only bytes 0..29 written
    send_frame(80, 1'b1, 30, 30, 1'b0);
    wait_drained("errors");

    // Fill to wptr=2000, release everything, then a frame straddling the end
    send_frame(968, 1'b1, -1, 968, 1'b1);
    send_frame(968, 1'b1, -1, 968, 1'b1);
    check("wptr_model_2000", m_wptr, 2000);
    release_bytes(64);
    release_bytes(968);
    release_bytes(968);
    send_frame(100, 1'b1, -1, 100, 1'b1);
    release_bytes(100);
    // Two max frames with no release: second runs out of space after 526 bytes
    send_frame(1522, 1'b1, -1, 1522, 1'b1);
    send_frame(1522, 1'b1, -1, 526, 1'b0);
    release_bytes(1522);
    wait_drained("wrap");

    // Backpressure: 8 commits fill the FIFO, ninth good frame is dropped
    @(posedge iclk); #1 dif.i_desc_ready = 1'b0;
    for (int k = 0; k < 8; k++) send_frame(64, 1'b1, -1, 64, 1'b1);
    send_frame(64, 1'b1, -1, 64, 1'b0);
    check("fifo_valid_stalled", dif.o_desc_valid, 1'b1);
    @(posedge iclk); #1 dif.i_desc_ready = 1'b1;
    wait_drained("backpressure");
    release_bytes(512);

    // Reset mid-frame at byte 40
    for (int i = 0; i < 40; i++)
      exp_wr.push_back({11'((m_wptr + i) % 2048), byte_for(i)});
    start_frame();
    for (int i = 0; i < 40; i++) drive_byte(i, 100, -1);
    @(negedge iclk);
    idv = 1'b0;
    #2 irst_n = 1'b0;
    istate = 3'b000; ichange = 1'b0;
    @(negedge iclk);
    check("midframe_reset_outputs", {o_mem_we, o_mem_waddr, o_mem_wdata, dif.o_desc_valid,
                                     dif.o_desc_addr, dif.o_desc_len, o_frame_cnt, o_drop_cnt,
                                     o_busy}, '0);
    check("midframe_writes_seen", exp_wr.size(), 0);
    m_wptr = 0; m_frame = 0; m_drop = 0; m_seq++;
    irst_n = 1'b1;
    repeat (2) @(negedge iclk);
    send_frame(64, 1'b1, -1, 64, 1'b1);
    wait_drained("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
